// File: rtl/sample_frame_buffer_pkg.sv
// rtl/sample_frame_buffer_pkg.sv - shared spectrum constants and bit-reversal helper
package sample_frame_buffer_pkg;

  localparam int N_POINTS = 512;
  localparam int ADDR_W   = 9;
  localparam int DATA_W   = 16;

  // Same mapping the FFT engine expects: bit i moves to bit 8-i.
  function automatic logic [8:0] bitrev9(input logic [8:0] a);
    logic [8:0] r;
    for (int i = 0; i < 9; i++) begin
      r[i] = a[8-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/sfb_bank_ram.sv
// rtl/sfb_bank_ram.sv - two-bank simple dual-port sample RAM with registered read
module sfb_bank_ram #(
  parameter int DATA_W = 16,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<AW)-1];

  // Array has no reset so it maps onto block RAM; only the output register clears.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/sample_frame_buffer.sv
// rtl/sample_frame_buffer.sv - ping-pong capture of bit-reversed 512-sample FFT frames
module sample_frame_buffer
  import sample_frame_buffer_pkg::bitrev9;
#(
  parameter int DATA_W = sample_frame_buffer_pkg::DATA_W,
  parameter int ADDR_W = sample_frame_buffer_pkg::ADDR_W
) (
  input  logic              Clk,
  input  logic              reset,
  input  logic              cnt_en,
  input  logic [ADDR_W-1:0] count,
  input  logic              md512,
  input  logic [DATA_W-1:0] sample_in,
  output logic              frame_ready,
  output logic              frame_bank,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              frame_ack,
  output logic              overflow
);

  logic              wb;
  logic              rb;
  logic              in_frame;
  logic              drop;
  logic [1:0]        full;
  logic [1:0]        full_next;
  logic [ADDR_W-1:0] wr_idx;
  logic              start;
  logic              fend;
  logic              ack;
  logic              wr_drop;
  logic              we;

  if (ADDR_W == 9) begin : g_rev9
    assign wr_idx = bitrev9(count);
  end else begin : g_revn
    always_comb begin
      wr_idx = '0;
      for (int i = 0; i < ADDR_W; i++) begin
        wr_idx[i] = count[ADDR_W-1-i];
      end
    end
  end

  assign start = cnt_en && !in_frame && (count == '0);
  assign fend  = cnt_en && md512 && in_frame;
  assign ack   = frame_ack && full[rb];

  // On the start cycle drop is not yet registered, so look at the bank flag directly.
  assign wr_drop = in_frame ? drop : full[wb];
  assign we      = cnt_en && (in_frame || start) && !wr_drop;

  always_comb begin
    full_next = full;
    if (fend && !drop) begin
      full_next[wb] = 1'b1;
    end
    if (ack) begin
      full_next[rb] = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      wb       <= 1'b0;
      rb       <= 1'b0;
      full     <= 2'b00;
      in_frame <= 1'b0;
      drop     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      full <= full_next;
      if (start) begin
        in_frame <= 1'b1;
        drop     <= full[wb];
        if (full[wb]) begin
          overflow <= 1'b1;
        end
      end
      if (fend) begin
        in_frame <= 1'b0;
        if (drop) begin
          drop <= 1'b0;
        end else begin
          wb <= ~wb;
        end
      end
      if (ack) begin
        rb <= ~rb;
      end
    end
  end

  assign frame_ready = full[rb];
  assign frame_bank  = rb;

  sfb_bank_ram #(
    .DATA_W (DATA_W),
    .AW     (ADDR_W + 1)
  ) u_ram (
    .clk   (Clk),
    .rst_n (reset),
    .we    (we),
    .waddr ({wb, wr_idx}),
    .wdata (sample_in),
    .raddr ({rb, rd_addr}),
    .rdata (rd_data)
  );

endmodule
